// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: stage strobes, imem/dmem handshakes, PC and status.
// Optional macro SINGLE_STEP_EN adds a step input and a STEP_WAIT pause after every retired instruction.
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        en_decode,
  output logic        en_execute,
  output logic        en_writeback,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WRITEBACK, S_PCUPD, S_HALTED, S_STEP_WAIT
  } state_t;

  localparam logic [2:0]  STAT_AOK = 3'd1;
  localparam logic [2:0]  STAT_HLT = 3'd2;
  localparam logic [2:0]  STAT_ADR = 3'd3;
  localparam logic [2:0]  STAT_INS = 3'd4;
  localparam bit          TO_EN    = (ACK_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST  = TO_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_t      state_r, state_s;
  logic [63:0] pc_r, pc_s;
  logic [2:0]  stat_r, stat_s;
  logic [3:0]  icode_r, icode_s;
  logic        cnd_r, cnd_s;
  logic [15:0] cnt_r, cnt_s;
  logic        imem_req_r, dmem_req_r, en_decode_r, en_execute_r, en_writeback_r;
  logic        busy_r, retired_r;
  logic        go_s, timeout_s;

  function automatic logic needs_mem(input logic [3:0] code);
    case (code)
      4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: needs_mem = 1'b1;
      default:                             needs_mem = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] next_pc(input logic [3:0] code, input logic taken,
                                          input logic [63:0] p, input logic [63:0] c,
                                          input logic [63:0] m);
    case (code)
      4'd7:    next_pc = taken ? c : p;
      4'd8:    next_pc = c;
      4'd9:    next_pc = m;
      default: next_pc = p;
    endcase
  endfunction

`ifdef SINGLE_STEP_EN
  assign go_s = start | step;
`else
  assign go_s = start;
`endif

  // Wait counter hits the limit on the last allowed cycle; an ack in that cycle still wins.
  assign timeout_s = TO_EN && (cnt_r == TO_LAST);

  // Next-state, next-PC and status selection.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    stat_s  = stat_r;
    icode_s = icode_r;
    cnd_s   = cnd_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (go_s) begin
          state_s = S_FETCH;
          cnt_s   = 16'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            stat_s  = STAT_ADR;
            state_s = S_HALTED;
          end else begin
            state_s = S_DECODE;
          end
        end else if (timeout_s) begin
          stat_s  = STAT_ADR;
          state_s = S_HALTED;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_DECODE: begin
        icode_s = icode;
        if (icode > 4'd11) begin
          stat_s  = STAT_INS;
          state_s = S_HALTED;
        end else if (icode == 4'd0) begin
          stat_s  = STAT_HLT;
          state_s = S_HALTED;
        end else begin
          state_s = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        cnd_s   = cnd;
        cnt_s   = 16'd0;
        state_s = S_MEMORY;
      end
      S_MEMORY: begin
        if (!needs_mem(icode_r)) begin
          state_s = S_WRITEBACK;
        end else if (dmem_ack) begin
          if (dmem_err) begin
            stat_s  = STAT_ADR;
            state_s = S_HALTED;
          end else begin
            state_s = S_WRITEBACK;
          end
        end else if (timeout_s) begin
          stat_s  = STAT_ADR;
          state_s = S_HALTED;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_WRITEBACK: begin
        // PC is loaded on entry to PCUPD so it is visible alongside the retired pulse.
        pc_s    = next_pc(icode_r, cnd_r, valP, valC, valM);
        state_s = S_PCUPD;
      end
      S_PCUPD: begin
        cnt_s = 16'd0;
`ifdef SINGLE_STEP_EN
        state_s = S_STEP_WAIT;
`else
        state_s = S_FETCH;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step) begin
          state_s = S_FETCH;
          cnt_s   = 16'd0;
        end else begin
          state_s = S_STEP_WAIT;
        end
      end
`endif
      S_HALTED: begin
        state_s = S_HALTED;
      end
      default: begin
        stat_s  = STAT_INS;
        state_s = S_HALTED;
      end
    endcase
  end

  // State, architectural registers and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      pc_r           <= RESET_PC;
      stat_r         <= STAT_AOK;
      icode_r        <= 4'd0;
      cnd_r          <= 1'b0;
      cnt_r          <= 16'd0;
      imem_req_r     <= 1'b0;
      dmem_req_r     <= 1'b0;
      en_decode_r    <= 1'b0;
      en_execute_r   <= 1'b0;
      en_writeback_r <= 1'b0;
      busy_r         <= 1'b0;
      retired_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      stat_r         <= stat_s;
      icode_r        <= icode_s;
      cnd_r          <= cnd_s;
      cnt_r          <= cnt_s;
      imem_req_r     <= (state_s == S_FETCH);
      dmem_req_r     <= (state_s == S_MEMORY) && needs_mem(icode_s);
      en_decode_r    <= (state_s == S_DECODE);
      en_execute_r   <= (state_s == S_EXECUTE);
      en_writeback_r <= (state_s == S_WRITEBACK);
      busy_r         <= !(state_s inside {S_IDLE, S_HALTED, S_STEP_WAIT});
      retired_r      <= (state_s == S_PCUPD);
    end
  end

  assign imem_req     = imem_req_r;
  assign dmem_req     = dmem_req_r;
  assign en_decode    = en_decode_r;
  assign en_execute   = en_execute_r;
  assign en_writeback = en_writeback_r;
  assign pc           = pc_r;
  assign stat         = stat_r;
  assign busy         = busy_r;
  assign retired      = retired_r;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Self-checking bench for y86_seq_controller: directed cases plus randomized instructions vs a reference model.
module tb_y86_seq_controller;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'd0;
  logic        cnd = 1'b0;
  logic [63:0] valP = 64'd0, valC = 64'd0, valM = 64'd0;
  logic        imem_ack = 1'b0, imem_err = 1'b0, dmem_ack = 1'b0, dmem_err = 1'b0;
  logic        imem_req, dmem_req, en_decode, en_execute, en_writeback, busy, retired;
  logic [63:0] pc;
  logic [2:0]  stat;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  y86_seq_controller #(.RESET_PC(RST_PC), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .icode(icode), .cnd(cnd), .valP(valP), .valC(valC), .valM(valM),
    .imem_ack(imem_ack), .imem_err(imem_err), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .imem_req(imem_req), .dmem_req(dmem_req), .en_decode(en_decode), .en_execute(en_execute),
    .en_writeback(en_writeback), .pc(pc), .stat(stat), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc, ireq_n, dreq_n, dec_cyc, exe_cyc, wb_cyc, ret_cyc, halt_cyc, dec_n, exe_n, wb_n, ret_n;
  bit done;
  logic [63:0] pc_at_ret;
  logic [15:0] mem_set = 16'b0000_1111_0011_0000;  // icodes 4,5,8,9,10,11 touch data memory

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_pc(input logic [3:0] ic, input logic c,
                                           input logic [63:0] vp, input logic [63:0] vc,
                                           input logic [63:0] vm);
    if (ic == 4'd8 || (ic == 4'd7 && c)) return vc;
    else if (ic == 4'd9) return vm;
    else return vp;
  endfunction

  // Acts as both memories for one instruction. fl/ml = request cycle in which ack arrives (0 = never).
  task automatic run(input logic [3:0] ic, input logic c, input logic [63:0] vp, input logic [63:0] vc,
                     input logic [63:0] vm, input int fl, input int ml, input bit fe, input bit me,
                     input bit kick, input bit noise);
    icode = ic; cnd = c; valP = vp; valC = vc; valM = vm;
    start = kick;
    cyc = 0; ireq_n = 0; dreq_n = 0; dec_cyc = 0; exe_cyc = 0; wb_cyc = 0; ret_cyc = 0; halt_cyc = 0;
    dec_n = 0; exe_n = 0; wb_n = 0; ret_n = 0; done = 1'b0; pc_at_ret = 64'd0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (imem_req) begin
        ireq_n++;
        imem_ack = (ireq_n == fl);
        imem_err = (ireq_n == fl) && fe;
      end else begin
        imem_ack = noise && dmem_req;
        imem_err = noise && dmem_req;
      end
      if (dmem_req) begin
        dreq_n++;
        dmem_ack = (dreq_n == ml);
        dmem_err = (dreq_n == ml) && me;
      end else begin
        dmem_ack = noise && imem_req;
        dmem_err = noise && imem_req;
      end
      // Inputs change after they were due to be latched, so only the latched copies may matter.
      if (en_decode) begin dec_n++; dec_cyc = cyc; end
      if (en_execute) begin exe_n++; exe_cyc = cyc; icode = 4'($urandom); end
      if (en_writeback) begin wb_n++; wb_cyc = cyc; cnd = ~c; end
      if (retired) begin ret_n++; ret_cyc = cyc; pc_at_ret = pc; done = 1'b1; end
      if (!busy) begin halt_cyc = cyc; done = 1'b1; end
    end
    start = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
  endtask

  task automatic expect_retire(input string tag, input logic [3:0] ic, input logic c,
                               input logic [63:0] vp, input logic [63:0] vc, input logic [63:0] vm,
                               input int fl, input int ml);
    int mc;
    mc = mem_set[ic] ? ml : 1;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".ret_cyc"}, 64'(ret_cyc), 64'(fl + 4 + mc));
    check({tag, ".pc"}, pc_at_ret, model_pc(ic, c, vp, vc, vm));
    check({tag, ".ireq"}, 64'(ireq_n), 64'(fl));
    check({tag, ".dreq"}, 64'(dreq_n), mem_set[ic] ? 64'(ml) : 64'd0);
    check({tag, ".order"}, {16'(dec_cyc), 16'(exe_cyc), 16'(wb_cyc), 16'(dec_n + exe_n + wb_n)},
          {16'(fl + 1), 16'(fl + 2), 16'(fl + 3 + mc), 16'd3});
    check({tag, ".stat"}, 64'(stat), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.pc", pc, RST_PC);
    check("rst.stat", 64'(stat), 64'd1);
    check("rst.outs", {58'd0, imem_req, dmem_req, en_decode, en_execute, en_writeback, retired}, 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  ric;
    logic        rc;
    logic [63:0] rvp, rvc, rvm, pc_prev;
    int          rfl, rml;
    bit          found;

    do_reset();
    run(4'd3, 1'b0, 64'h10A, 64'h55, 64'h66, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_retire("irmovq", 4'd3, 1'b0, 64'h10A, 64'h55, 64'h66, 2, 1);
    run(4'd7, 1'b1, 64'h109, 64'h200, 64'h0, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_retire("jxx_taken", 4'd7, 1'b1, 64'h109, 64'h200, 64'h0, 2, 1);
    run(4'd7, 1'b0, 64'h109, 64'h200, 64'h0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_retire("jxx_not", 4'd7, 1'b0, 64'h109, 64'h200, 64'h0, 1, 1);
    run(4'd9, 1'b0, 64'h20B, 64'h77, 64'h3C0, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_retire("ret", 4'd9, 1'b0, 64'h20B, 64'h77, 64'h3C0, 2, 3);

    for (int i = 0; i < 24; i++) begin
      ric = 4'($urandom_range(1, 11));
      rc  = 1'($urandom_range(0, 1));
      rvp = {$urandom, $urandom}; rvc = {$urandom, $urandom}; rvm = {$urandom, $urandom};
      rfl = $urandom_range(1, 4); rml = $urandom_range(1, 4);
      run(ric, rc, rvp, rvc, rvm, rfl, rml, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_retire("rand", ric, rc, rvp, rvc, rvm, rfl, rml);
    end

    pc_prev = pc;
    run(4'd0, 1'b0, 64'h999, 64'h888, 64'h777, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("halt.stat", 64'(stat), 64'd2);
    check("halt.cyc", 64'(halt_cyc), 64'd4);
    check("halt.pc", pc, pc_prev);
    check("halt.exe", 64'(exe_n), 64'd0);
    repeat (6) begin
      @(negedge clk);
      start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    check("halted.hold", {pc, 58'd0, stat, busy, imem_req, dmem_req}, {pc_prev, 58'd0, 3'd2, 3'd0});

    do_reset();
    run(4'hE, 1'b0, 64'h1, 64'h2, 64'h3, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ins.stat", 64'(stat), 64'd4);
    check("ins.strobes", {32'(dec_n), 32'(exe_n)}, {32'd1, 32'd0});
    check("ins.cyc", 64'(halt_cyc), 64'd3);

    do_reset();
    run(4'd3, 1'b0, 64'h1, 64'h2, 64'h3, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ifetch_err.stat", 64'(stat), 64'd3);
    check("ifetch_err.dec", 64'(dec_n), 64'd0);
    check("ifetch_err.pc", pc, RST_PC);

    do_reset();
    run(4'd3, 1'b0, 64'h1, 64'h2, 64'h3, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("itimeout.ireq", 64'(ireq_n), 64'd4);
    check("itimeout.cyc", 64'(halt_cyc), 64'd5);
    check("itimeout.stat", 64'(stat), 64'd3);

    do_reset();
    run(4'd5, 1'b0, 64'h1, 64'h2, 64'h3, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    check("dmem_err.stat", 64'(stat), 64'd3);
    check("dmem_err.dreq_wb", {32'(dreq_n), 32'(wb_n)}, {32'd2, 32'd0});

    do_reset();
    run(4'd10, 1'b0, 64'h1, 64'h2, 64'h3, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dtimeout.dreq", 64'(dreq_n), 64'd4);
    check("dtimeout.stat", {61'd0, stat}, {61'd0, 3'd3});
    check("dtimeout.req_low", {62'd0, imem_req, dmem_req}, 64'd0);

    do_reset();
    icode = 4'd4; valP = 64'h5555;
    start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      imem_ack = imem_req;
      found = dmem_req;
    end
    imem_ack = 1'b0;
    check("midmem.reached", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midmem.dreq", 64'(dmem_req), 64'd0);
    check("midmem.pc", pc, RST_PC);
    check("midmem.busy_stat", {60'd0, busy, stat}, {60'd0, 1'b0, 3'd1});
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ datapath.
- Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC-update. It emits a single-cycle enable strobe per stage and runs req/ack handshakes to instruction and data memory.
- Owns the architectural PC register and the processor status register.
- Sits above the stage modules; replaces free-running per-stage clocking with explicit sequencing.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- ACK_TIMEOUT, 16, maximum cycles to wait for imem_ack/dmem_ack. 0 = wait forever.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE and begins execution at current pc.
- icode  in  4  instruction code from fetch, sampled while en_decode is high.
- cnd  in  1  condition flag from execute, sampled in EXECUTE.
- valP  in  64  fall-through address.
- valC  in  64  constant / jump target.
- valM  in  64  memory read value (return address for ret).
- imem_ack  in  1  instruction memory done.
- imem_err  in  1  instruction fetch address error; valid with imem_ack.
- dmem_ack  in  1  data memory done.
- dmem_err  in  1  data address error; valid with dmem_ack.
- imem_req  out  1  instruction fetch request, held until ack.
- dmem_req  out  1  data access request, held until ack.
- en_decode, en_execute, en_writeback  out  1 each  single-cycle stage strobes.
- pc  out  64  architectural PC.
- stat  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- busy  out  1  high in every state except IDLE and HALTED.
- retired  out  1  single-cycle pulse when the PC-update stage completes.

Behaviour:
- Clock/reset fixed: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE, pc = RESET_PC, stat = AOK, all req/strobe/retired outputs = 0, cnd latch = 0, icode latch = 0, timeout counter = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- IDLE: start = 1 moves to FETCH next cycle.
- FETCH: imem_req = 1 until imem_ack.
  - ack with err = 0 -> DECODE.
  - ack with err = 1 -> stat = ADR, HALTED.
- DECODE: en_decode = 1 for one cycle; icode latched.
  - icode > 11 -> stat = INS, HALTED (no further strobes).
  - icode = 0 (halt) -> stat = HLT, HALTED; pc unchanged.
  - otherwise -> EXECUTE.
- EXECUTE: en_execute = 1 for one cycle; cnd latched -> MEMORY.
- MEMORY:
  - dmem_req = 1 only for icode 4, 5, 8, 9, 10, 11; held until dmem_ack.
  - ack with err = 1 -> stat = ADR, HALTED.
  - icode not needing memory -> WRITEBACK immediately; dmem_req stays 0.
- WRITEBACK: en_writeback = 1 for one cycle -> PCUPD.
- PCUPD: pc loaded, retired = 1, -> FETCH. Next-PC selection:
  - icode 7: cnd latch ? valC : valP.
  - icode 8: valC.
  - icode 9: valM.
  - all other valid codes: valP.
- Minimum latency, non-memory instruction with 1-cycle ack: FETCH (2) + DECODE + EXECUTE + MEMORY + WRITEBACK + PCUPD = 7 cycles.
- Timeout:
  - Counter clears on entry to FETCH/MEMORY and increments each waiting cycle.
  - Count reaching ACK_TIMEOUT with no ack -> stat = ADR, req dropped, HALTED.
  - An ack in the same cycle as the limit wins.
- Acks arriving outside a matching req are ignored.
- HALTED: holds pc and stat; only reset exits. start is ignored.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values; any outstanding req drops asynchronously.
- Width rules: all PC sources are 64-bit; no arithmetic in this block. valP is computed by fetch.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: adds input step (1 bit). After PCUPD the FSM enters STEP_WAIT (busy = 0) instead of FETCH, and proceeds to FETCH on step = 1. start in IDLE behaves as step.
- Undefined: no step port; PCUPD goes directly to FETCH.

Test Plan:
- Reset with RESET_PC = 64'h100, then start; irmovq (icode 3), valP = 64'h10A, acks 1 cycle -> strobes in order, dmem_req never high, retired at cycle 7, pc = 64'h10A.
- jXX icode 7, valC = 64'h200, valP = 64'h109: cnd = 1 -> pc = 64'h200; repeat with cnd = 0 -> pc = 64'h109.
- ret icode 9, dmem_ack after 3 cycles, valM = 64'h3C0 -> dmem_req held exactly 3 cycles, pc = 64'h3C0.
- icode 0 -> stat = 2, HALTED, pc unchanged, busy = 0. Later start and acks -> no change.
- icode 4'hE -> stat = 4 after decode. Separately, imem_err with ack -> stat = 3, no en_decode.
- ACK_TIMEOUT = 4, no imem_ack -> imem_req high 4 cycles then low, stat = 3. Separately, assert rst_n = 0 mid-MEMORY -> dmem_req = 0 immediately, pc = RESET_PC.
